// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the sequencer state encoding and the counter width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Keep at least one bit so a degenerate width still elaborates.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit combinational full subtractor: d = a - b - bin, with the borrow out.
// It is the counterpart of full_adder and is shared across every bit position.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with valid/ready on both sides.
// One full_subtractor cell plus a borrow flop produces one result bit per RUN cycle.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             br_q,    br_d;
    logic             d_bit;
    logic             bout_bit;

    full_subtractor u_fs (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (d_bit),
        .bout_o (bout_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = borrow_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Result enters at the MSB so the LSB-first bits land in place after WIDTH shifts.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = bout_bit;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
        end
    end

    // All outputs decode registered state only.
    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q == S_RUN);
    assign diff       = res_q;
    assign borrow_out = br_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed corner cases plus random operands,
// expected results computed with plain wide arithmetic and checked by a separate monitor.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;

    int passed = 0;
    int total  = 0;

    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: the borrow is the sign bit of the widened difference.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bin);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: one pop per accepted output transfer.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(diff), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("diff", 32'(diff), 32'(e[W-1:0]));
                    check("borrow_out", 32'(borrow_out), 32'(e[W]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand and hold it until the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                         input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        borrow_in = bin;
        if (push) exp_q.push_back(model(x, y, bin));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        if (!out_valid) check("wait_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            tick();
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [W-1:0] ra, rb;
        logic         rbin;
        logic [W:0]   e;

        // Reset state while rst is held.
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow_out", 32'(borrow_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic subtraction and latency.
        out_ready = 1'b1;
        issue(8'h05, 8'h03, 1'b0, 1'b1);
        check("busy_in_run", 32'(busy), 32'd1);
        check("in_ready_in_run", 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(W));
        wait_drain();

        issue(8'h03, 8'h05, 1'b0, 1'b1);
        wait_drain();
        issue(8'h00, 8'h00, 1'b1, 1'b1);
        wait_drain();
        issue(8'hA5, 8'hA5, 1'b0, 1'b1);
        wait_drain();

        // Backpressure: result must hold until accepted.
        out_ready = 1'b0;
        issue(8'h80, 8'h01, 1'b0, 1'b1);
        wait_valid(cyc);
        e = model(8'h80, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_diff", 32'(diff), 32'(e[W-1:0]));
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_back_idle_valid", 32'(out_valid), 32'd0);
        check("bp_back_idle_ready", 32'(in_ready), 32'd1);
        wait_drain();

        // New operands held during RUN are ignored until IDLE.
        issue(8'h40, 8'h11, 1'b1, 1'b1);
        in_valid  = 1'b1;
        a         = 8'h22;
        b         = 8'h33;
        borrow_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ignore_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        exp_q.push_back(model(8'h22, 8'h33, 1'b0));
        tick();
        in_valid = 1'b0;
        wait_drain();

        // Reset in the middle of RUN discards the operation.
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        issue(8'h10, 8'h01, 1'b0, 1'b1);
        wait_drain();

        // Random operands with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            issue(ra, rb, rbin, 1'b1);
            wait_valid(cyc);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
            out_ready = 1'b1;
            tick();
        end
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
